// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : MEM-stage data-memory interface. Runs a req/ack bus transaction
//             per load/store, formats byte enables / store data, extracts and
//             extends load data, and stalls the pipeline while busy.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic [31:0] load_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_error
);

    // Counter is wide enough to hold BUS_TIMEOUT itself; the timeout fires on
    // the BUS_TIMEOUT-th REQ cycle, i.e. when the count equals BUS_TIMEOUT-1.
    localparam int              c_CW     = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam bit              c_TMO_EN = (BUS_TIMEOUT != 0);
    localparam logic [c_CW-1:0] c_LIMIT  = (BUS_TIMEOUT > 0) ? c_CW'(BUS_TIMEOUT - 1) : '0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    // Latched access attributes
    logic            r_is_load;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            r_err;
    logic [c_CW-1:0] r_cnt;

    // Registered bus-side outputs and load result
    logic            r_bus_we;
    logic [31:0]     r_bus_addr;
    logic [31:0]     r_bus_wdata;
    logic [3:0]      r_bus_be;
    logic [31:0]     r_load_data;

    // Request decode
    logic            w_req;
    logic            w_legal;
    logic            w_misaligned;
    logic            w_ok;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_timeout;

    // Load formatting
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_fmt;

    // Decode the incoming request: legality, alignment, lanes and store data
    always_comb begin
        w_req   = req_valid & (mem_read | mem_write);
        w_legal = 1'b0;
        case (funct3)
            c_F3_B, c_F3_H, c_F3_W: w_legal = 1'b1;
            c_F3_BU, c_F3_HU:       w_legal = mem_read;   // unsigned forms exist only for loads
            default:                w_legal = 1'b0;
        endcase
        w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_ok = w_legal & ~w_misaligned;

        w_be    = 4'b1111;
        w_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Select the addressed lane of the returned word and extend it
    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_f3)
            c_F3_B:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_fmt = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_load_fmt = {24'd0, w_byte};
            c_F3_HU: w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = bus_rdata;
        endcase
    end

    // Timeout detection on the bus wait
    always_comb begin
        w_timeout = c_TMO_EN && (r_cnt == c_LIMIT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: bad requests skip the bus and go straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_next_state = w_ok ? c_REQ : c_DONE;
                end
            end
            c_REQ: begin
                if (bus_ack || w_timeout) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic derived from state and the incoming request
    always_comb begin
        bus_req   = (r_state == c_REQ);
        lsu_stall = ((r_state == c_IDLE) && w_req) || (r_state == c_REQ);
        lsu_done  = (r_state == c_DONE);
        lsu_error = (r_state == c_DONE) && r_err;
    end

    // Access latch, wait counter, error flag and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_load   <= 1'b0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_err <= ~w_ok;
                        r_cnt <= '0;
                        if (w_ok) begin
                            r_is_load   <= mem_read;
                            r_f3        <= funct3;
                            r_off       <= addr[1:0];
                            r_bus_we    <= ~mem_read;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                c_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_ack) begin
                        if (r_is_load) begin
                            r_load_data <= w_load_fmt;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Directed self-checking bench for load_store_unit with a
//             transaction-level reference model and per-cycle comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, mem_read, mem_write, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, bus_rdata;
    logic        bus_req, bus_we, lsu_stall, lsu_done, lsu_error;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected per-cycle outputs
    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_done, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;

    // Per-transaction observations
    int          stall_cnt, done_cnt, req_cnt, done_idx, err_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    load_store_unit #(.BUS_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .load_data  (load_data),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .lsu_error  (lsu_error)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, want, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_legal(input logic rd, input logic [2:0] f3);
        if (rd) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        int sz;
        sz = 1 << f3[1:0];
        if (sz > 4) sz = 4;
        return sz;
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        int sz, base;
        sz   = m_size(f3);
        base = int'(off) & ~(sz - 1);
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (m_size(f3))
            1:       return {24'd0, sd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, sd[15:0]} * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [63:0] v, span;
        int sz, sh;
        sz   = m_size(f3);
        sh   = 8 * (int'(off) & ~(sz - 1));
        span = 64'd1 << (8 * sz);
        v    = (64'(rd) >> sh) & (span - 64'd1);
        if (!f3[2] && sz < 4 && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("bus_req",   32'(bus_req),   32'(exp_req));
            cmp("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
            cmp("lsu_done",  32'(lsu_done),  32'(exp_done));
            cmp("lsu_error", 32'(lsu_error), 32'(exp_err));
            cmp("load_data", load_data, exp_ld);
            if (exp_req) begin
                cmp("bus_addr", bus_addr, exp_addr);
                cmp("bus_we",   32'(bus_we), 32'(exp_we));
                cmp("bus_be",   32'(bus_be), 32'(exp_be));
                if (exp_we) cmp("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    task automatic set_idle_exp();
        exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic observe(input int idx);
        @(negedge clk);
        if (lsu_stall) stall_cnt++;
        if (lsu_done) begin done_cnt++; done_idx = idx; end
        if (lsu_error) err_cnt++;
        if (bus_req) begin
            req_cnt++;
            cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
        end
    endtask

    // One complete access; ack_at = REQ cycle carrying bus_ack (0 = never)
    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdata);
        bit ok, acked, tmo;
        int k;
        ok = m_legal(rd, f3) && m_aligned(f3, a);
        acked = 0; tmo = 0; k = 0;
        stall_cnt = 0; done_cnt = 0; req_cnt = 0; done_idx = -1; err_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; bus_ack = 1'b0; bus_rdata = rdata;
        exp_req = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
        observe(0);
        if (ok) begin
            while (!acked && !tmo) begin
                k++;
                @(posedge clk); #1;
                bus_ack   = (k == ack_at);
                exp_req   = 1'b1; exp_stall = 1'b1;
                exp_addr  = {a[31:2], 2'b00};
                exp_we    = !rd;
                exp_be    = m_be(f3, a[1:0]);
                exp_wdata = m_wdata(f3, sd);
                observe(k);
                if (k == ack_at) acked = 1;
                else if (k == TMO) tmo = 1;
            end
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_err = !ok || tmo;
        if (ok && acked && rd) exp_ld = m_load(f3, a[1:0], rdata);
        observe(k + 1);
        // pipeline has advanced; a stray ack in IDLE must be ignored
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b1;
        set_idle_exp();
        observe(k + 2);
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        exp_ld = 32'd0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_bus_req",   32'(bus_req),   32'd0);
        cmp("rst_bus_we",    32'(bus_we),    32'd0);
        cmp("rst_bus_addr",  bus_addr,       32'd0);
        cmp("rst_bus_wdata", bus_wdata,      32'd0);
        cmp("rst_bus_be",    32'(bus_be),    32'd0);
        cmp("rst_load_data", load_data,      32'd0);
        cmp("rst_done",      32'(lsu_done),  32'd0);
        cmp("rst_stall",     32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // LW 0x100, ack in third REQ cycle
        xact(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 3, 32'hDEAD_BEEF);
        cmp("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        cmp("lw_done_pulses",  32'(done_cnt),  32'd1);
        cmp("lw_load_data",    load_data,      32'hDEAD_BEEF);
        cmp("lw_be",           32'(cap_be),    32'hF);

        // LB / LBU at 0x203, zero-wait
        xact(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 1, 32'h80FF_7F01);
        cmp("lb_be",        32'(cap_be),   32'b1000);
        cmp("lb_done_idx",  32'(done_idx), 32'd2);
        cmp("lb_load_data", load_data,     32'hFFFF_FF80);
        xact(1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 1, 32'h80FF_7F01);
        cmp("lbu_load_data", load_data,    32'h0000_0080);

        // SH at 0x306
        xact(1'b0, 1'b1, 3'b001, 32'h306, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
        cmp("sh_addr",      cap_addr,      32'h304);
        cmp("sh_be",        32'(cap_be),   32'b1100);
        cmp("sh_wdata",     cap_wdata,     32'hABCD_ABCD);
        cmp("sh_we",        32'(cap_we),   32'd1);
        cmp("sh_load_data", load_data,     32'h0000_0080);

        // Misaligned LW and illegal load funct3
        xact(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1, 32'h5555_5555);
        cmp("mis_req_cycles", 32'(req_cnt),  32'd0);
        cmp("mis_done_idx",   32'(done_idx), 32'd1);
        cmp("mis_err_pulses", 32'(err_cnt),  32'd1);
        xact(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 1, 32'h5555_5555);
        cmp("ill_req_cycles", 32'(req_cnt),  32'd0);
        cmp("ill_done_idx",   32'(done_idx), 32'd1);

        // Timeout: ack never arrives
        xact(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 0, 32'h0);
        cmp("tmo_req_cycles", 32'(req_cnt), 32'd4);
        cmp("tmo_err_pulses", 32'(err_cnt), 32'd1);
        cmp("tmo_load_data",  load_data,    32'h0000_0080);

        // Further width / sign / lane patterns
        xact(1'b1, 1'b0, 3'b001, 32'h402, 32'd0, 2, 32'h8001_7FFF);
        cmp("lh_load_data", load_data, 32'hFFFF_8001);
        xact(1'b1, 1'b0, 3'b101, 32'h400, 32'd0, 1, 32'h0000_F00D);
        cmp("lhu_load_data", load_data, 32'h0000_F00D);
        xact(1'b0, 1'b1, 3'b000, 32'h501, 32'h0000_00AB, 1, 32'h0);
        cmp("sb_be",    32'(cap_be), 32'b0010);
        cmp("sb_wdata", cap_wdata,   32'hABAB_ABAB);
        xact(1'b0, 1'b1, 3'b010, 32'h800, 32'hCAFE_F00D, 2, 32'h0);
        xact(1'b1, 1'b1, 3'b100, 32'h700, 32'h9999_9999, 1, 32'h1234_5678);
        cmp("rdwr_is_load", load_data, 32'h0000_0078);
        xact(1'b0, 1'b1, 3'b100, 32'h700, 32'd0, 1, 32'h0);
        cmp("store_f3_100_err", 32'(err_cnt), 32'd1);
        xact(1'b0, 1'b1, 3'b001, 32'h303, 32'd0, 1, 32'h0);
        cmp("sh_mis_err", 32'(err_cnt), 32'd1);

        // Reset during REQ, then a late ack
        done_cnt = 0; stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h600;
        exp_req = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
        observe(0);
        @(posedge clk); #1;
        exp_req = 1'b1; exp_addr = 32'h600; exp_we = 1'b0; exp_be = 4'hF;
        observe(1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        observe(2);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; mem_read = 1'b0;
        set_idle_exp();
        exp_ld = 32'd0;
        @(negedge clk);
        cmp("rst_mid_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        observe(4);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        observe(5);
        observe(6);
        cmp("rst_mid_done_pulses", 32'(done_cnt), 32'd0);
        cmp("rst_mid_err_pulses",  32'(err_cnt),  32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
